// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: widths, reset PC and fetch-stage bundles.
// Used by instr_fetch (optional FETCH_MISALIGN_CHECK_EN) and its FIFO.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for the fetch buffer; flush beats push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem request/response tracking, {pc,instr} buffer.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect traps into sticky FAULT.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            accept;
    logic            misaligned;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned  = |redirect_pc[1:0];
    assign target      = redirect_pc;
    assign fetch_fault = (state == FAULT);
`else
    assign misaligned  = 1'b0;
    assign target      = redirect_pc & ~32'd3;
    assign fetch_fault = 1'b0;
`endif

    // Credit counts in-flight words so every response has a FIFO slot.
    assign in_use = {1'b0, fifo_count} + {1'b0, outstanding};

    assign imem_req_valid = !reset && (state == FETCH) && !redirect_valid
                         && (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && !redirect_valid
               && (state == FETCH) && (discard_cnt == '0);

    assign out_valid = !reset && (state == FETCH)
                    && !fifo_empty && !redirect_valid;
    assign pop       = out_valid && out_ready;

    assign wr_entry  = '{pc: rsp_pc, instr: imem_rsp_data};
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc          <= target;
                rsp_pc      <= target;
                discard_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (push) rsp_pc <= rsp_pc + 32'd4;
                if (imem_rsp_valid && (discard_cnt != '0))
                    discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: if (redirect_valid && misaligned) state_next = FAULT;
            FAULT: state_next = FAULT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) assert (!(push && fifo_full));
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
